// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types, add-3 correction and segment patterns
// for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // {g,f,e,d,c,b,a}, active-low
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic bcd_t add3(input bcd_t d);
    return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq.
// out_seg exists only with BIN2BCD_SEG7_EN.
interface bin_to_bcd_seq_if #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
`ifdef BIN2BCD_SEG7_EN
  logic [7*DIGITS-1:0]   out_seg;
`endif

  modport slave (
    input  in_valid, in_bin, out_ready,
`ifdef BIN2BCD_SEG7_EN
    output out_seg,
`endif
    output in_ready, out_valid, out_bcd
  );

  modport master (
    output in_valid, in_bin, out_ready,
`ifdef BIN2BCD_SEG7_EN
    input  out_seg,
`endif
    input  in_ready, out_valid, out_bcd
  );
endinterface

// File: rtl/bin_to_bcd_seq_seg7.sv
// One BCD digit to 7 active-low segments.
// Non-decimal codes blank the digit.
module seg7_digit_dec
  import bcd_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);
  always_comb begin
    seg = SEG_BLANK;
    unique case (1'b1)
      (bcd == 4'd0): seg = SEG_0;
      (bcd == 4'd1): seg = SEG_1;
      (bcd == 4'd2): seg = SEG_2;
      (bcd == 4'd3): seg = SEG_3;
      (bcd == 4'd4): seg = SEG_4;
      (bcd == 4'd5): seg = SEG_5;
      (bcd == 4'd6): seg = SEG_6;
      (bcd == 4'd7): seg = SEG_7;
      (bcd == 4'd8): seg = SEG_8;
      (bcd == 4'd9): seg = SEG_9;
      default:       seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD, one bit per clock.
// BIN2BCD_SEG7_EN adds registered 7-segment outputs.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_to_bcd_seq_if.slave    bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  function automatic bit range_ok();
    longint p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((longint'(1) << IN_W) - 1);
  endfunction

  if (IN_W < 1 || !range_ok()) begin : g_chk
    $error("bin_to_bcd_seq: DIGITS too small for IN_W");
  end

  logic [1:0]         state;
  logic [IN_W-1:0]    bin_sr;
  logic [BW-1:0]      bcd_sr;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      adj;
  logic [BW+IN_W-1:0] sr_nx;
  logic [BW-1:0]      bcd_nx;
  logic [IN_W-1:0]    bin_nx;
  logic [BW-1:0]      bcd_q;

  // Correct every digit first, then shift the joint register
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = add3(bcd_sr[4*i +: 4]);
    sr_nx  = {adj, bin_sr} << 1;
    bcd_nx = sr_nx[BW+IN_W-1:IN_W];
    bin_nx = sr_nx[IN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_sr <= bus.in_bin;
            bcd_sr <= '0;
            cnt    <= CW'(IN_W);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr <= bin_nx;
          bcd_sr <= bcd_nx;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q <= bcd_nx;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_bcd   = bcd_q;

`ifdef BIN2BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_nx;
  logic [7*DIGITS-1:0] seg_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_seg
    seg7_digit_dec u_dec (
      .bcd (bcd_nx[4*d +: 4]),
      .seg (seg_nx[7*d +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      seg_q <= '1;
    else if (state == SHIFT && cnt == CW'(1))
      seg_q <= seg_nx;
  end

  assign bus.out_seg = seg_q;
`endif

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one iteration per clock.
- Generalises the fixed 7-bit, two-digit combinational converter to any input width and digit count.
- Adds valid/ready handshakes on input and output.
- Sits between binary counters/arithmetic and the 7-segment display drivers.

Parameters:
- IN_W, 7, input binary width (>=1).
- DIGITS, 3, number of BCD output digits. Elaboration error if 10^DIGITS <= 2^IN_W - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_bin is valid.
- in_ready  out  1  block can accept an input.
- in_bin  in  IN_W  unsigned binary value.
- out_valid  out  1  out_bcd holds a completed result.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  packed BCD; digit i is bits [4i+3:4i], digit 0 is the least significant.
- out_seg  out  7*DIGITS  only when BIN2BCD_SEG7_EN is defined; see Optional Feature.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, in_ready=1, out_valid=0, out_bcd=0, internal shift/count registers=0. Any conversion in progress is discarded.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load bin_sr<=in_bin, bcd_sr<=0, cnt<=IN_W, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: every 4-bit digit of bcd_sr >=5 gets +3 (mod 16 per digit, no carry between digits). Then {bcd_sr,bin_sr} shifts left by 1 and cnt decrements.
  - When the iteration that brings cnt to 0 completes, load out_bcd<=final bcd_sr and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid is high from cycle IN_W+1 (i.e. after IN_W shift edges).
  - Throughput is one result per IN_W+2 cycles with out_ready held high.
- out_bcd:
  - Changes only on the SHIFT->DONE transition.
  - Stable while out_valid=1, and holds the last result afterwards.
- in_valid while not in IDLE is ignored; no input buffering.
- out_ready while not in DONE is ignored.
- Every digit of out_bcd is always <=9.
- Maximum input (2^IN_W-1) converts exactly, with no overflow path.
- rst_n low during SHIFT or DONE returns to IDLE on that edge with all outputs at reset values.

Optional Feature:
- Macro: BIN2BCD_SEG7_EN.
- Defined:
  - out_seg is present. Per digit, 7 bits ordered {g,f,e,d,c,b,a}, active-low, registered together with out_bcd (same cycle, same stability rules). Reset value is all 1s (blank).
  - Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Undefined: out_seg port and decoder logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - BCD digit type (4 bits) and segment vector type (7 bits).
  - add3 correction function.
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - FSM state enum.
- One sub-module, seg7_digit_dec: one BCD digit to 7 active-low segments, combinational. Instantiated DIGITS times under BIN2BCD_SEG7_EN.

Test Plan:
- IN_W=7, DIGITS=3; in_bin=99 with out_ready=1 -> out_valid rises 8 cycles after the accept edge, out_bcd=0x099.
- in_bin=127 -> 0x127; in_bin=0 -> 0x000; in_bin=10 -> 0x010. Sweep all 0..127 against a reference model, each digit <=9.
- Backpressure: in_bin=45, out_ready=0 for 6 cycles -> out_bcd=0x045 stable, out_valid=1, in_ready=0 throughout; in_valid pulses ignored. Releasing out_ready -> IDLE next cycle.
- Reset mid-conversion: accept 88, assert rst_n=0 at the 3rd SHIFT cycle -> next cycle out_valid=0, out_bcd=0, in_ready=1; a fresh 88 then yields 0x088.
- IN_W=10, DIGITS=4, in_bin=1023 -> 0x1023 after 10 shift cycles. Back-to-back inputs with in_valid held high -> results spaced 12 cycles apart.
- BIN2BCD_SEG7_EN defined, in_bin=81 -> out_seg digit1=0000000, digit0=1111001, digit2=1000000; after reset all segments =1.
